// File: rtl/soc_vga_console_if.sv
// Console register bus between the host (testbench or CPU) and the console
// block. One request per transaction: valid is sampled, ready answers one
// cycle later together with the read data.
interface soc_vga_console_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              uart_valid;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic [3:0]        uart_wstrb;
  logic [DATA_W-1:0] uart_rdata;
  logic              uart_ready;

  modport master (
    output uart_valid, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready
  );

  modport slave (
    input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready
  );
endinterface

// File: rtl/soc_vga_console_top.sv
// VGA console SoC simulation top: register-bus console with a 16-byte echo
// FIFO, image-memory load registers, a sticky trap flag, a 2^19 x 16 image
// memory with one external read port, and a 640x480 scan generator whose
// RGB and sync outputs are aligned to a two-stage address->data->RGB loop.
module soc_vga_console_top #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             trap,
  soc_vga_console_if.slave bus,
  input  logic             im_r_en,
  input  logic [18:0]      im_r_addr,
  output logic [15:0]      im_r_data,
  input  logic [11:0]      pixel,
  output logic             v_sync,
  output logic             h_sync,
  output logic [3:0]       Red,
  output logic [3:0]       Green,
  output logic [3:0]       Blue,
  output logic [31:0]      pixel_ADDR
);

  localparam logic [ADDR_W-1:0] REG_SOFTRESET = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_DIV       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_TXDATA    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_TXEN      = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_TXREADY   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] REG_RXDATA    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] REG_RXEN      = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] REG_RXREADY   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] REG_IM_ADDR   = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] REG_IM_WDATA  = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] REG_TRAP      = ADDR_W'(10);

  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;

  // console bus and register state
  logic              ready_r;
  logic [DATA_W-1:0] rdata_r;
  logic [15:0]       div_r;
  logic              txen_r;
  logic              rxen_r;
  logic [18:0]       im_addr_r;

  // echo FIFO
  logic [7:0] fifo_mem_r [0:15];
  logic [3:0] rd_ptr_r;
  logic [3:0] wr_ptr_r;
  logic [4:0] count_r;

  // image memory (contents are deliberately not reset)
  logic [15:0] image_mem_r [0:524287];

  // scan generator
  logic [9:0] hcnt_r;
  logic [9:0] vcnt_r;
  logic       act_d1_r;
  logic       hs_d1_r;
  logic       vs_d1_r;

  logic              accept_s;
  logic              wr_s;
  logic              rd_s;
  logic              full_s;
  logic              empty_s;
  logic              flush_s;
  logic              push_s;
  logic              pop_s;
  logic              im_we_s;
  logic              trap_set_s;
  logic [DATA_W-1:0] rdata_nxt_s;
  logic              active_s;
  logic              hs_raw_s;
  logic              vs_raw_s;
  logic              unused_wdata_s;

  assign bus.uart_ready = ready_r;
  assign bus.uart_rdata = rdata_r;
  assign unused_wdata_s = ^bus.uart_wdata[DATA_W-1:19];

  // Request decode; a valid arriving while ready is high belongs to the
  // finishing transaction and is not accepted again.
  always_comb begin
    accept_s   = bus.uart_valid & ~ready_r;
    wr_s       = accept_s & (bus.uart_wstrb != 4'd0);
    rd_s       = accept_s & (bus.uart_wstrb == 4'd0);
    full_s     = (count_r == 5'd16);
    empty_s    = (count_r == 5'd0);
    flush_s    = wr_s & (bus.uart_addr == REG_SOFTRESET) & bus.uart_wdata[0];
    push_s     = wr_s & (bus.uart_addr == REG_TXDATA) & txen_r & ~full_s;
    pop_s      = rd_s & (bus.uart_addr == REG_RXDATA) & rxen_r & ~empty_s;
    im_we_s    = wr_s & (bus.uart_addr == REG_IM_WDATA);
    trap_set_s = wr_s & (bus.uart_addr == REG_TRAP) & bus.uart_wdata[0];
  end

  // Read-data mux; write-only and unmapped words read as zero.
  always_comb begin
    rdata_nxt_s = {DATA_W{1'b0}};
    if (rd_s) begin
      case (bus.uart_addr)
        REG_DIV:     rdata_nxt_s[15:0] = div_r;
        REG_TXEN:    rdata_nxt_s[0]    = txen_r;
        REG_TXREADY: rdata_nxt_s[0]    = txen_r & ~full_s;
        REG_RXDATA: begin
          if (pop_s) begin
            rdata_nxt_s[7:0] = fifo_mem_r[rd_ptr_r];
          end else begin
            rdata_nxt_s[7:0] = 8'd0;
          end
        end
        REG_RXEN:    rdata_nxt_s[0]    = rxen_r;
        REG_RXREADY: rdata_nxt_s[0]    = rxen_r & ~empty_s;
        REG_IM_ADDR: rdata_nxt_s[18:0] = im_addr_r;
        default:     rdata_nxt_s       = {DATA_W{1'b0}};
      endcase
    end else begin
      rdata_nxt_s = {DATA_W{1'b0}};
    end
  end

  // One-cycle ready pulse with its read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      ready_r <= accept_s;
      rdata_r <= rdata_nxt_s;
    end
  end

  // Control registers, image write pointer and the sticky trap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r     <= 16'd0;
      txen_r    <= 1'b0;
      rxen_r    <= 1'b0;
      im_addr_r <= 19'd0;
      trap      <= 1'b0;
    end else begin
      if (wr_s && (bus.uart_addr == REG_DIV)) div_r <= bus.uart_wdata[15:0];
      if (wr_s && (bus.uart_addr == REG_TXEN)) txen_r <= bus.uart_wdata[0];
      if (wr_s && (bus.uart_addr == REG_RXEN)) rxen_r <= bus.uart_wdata[0];
      if (wr_s && (bus.uart_addr == REG_IM_ADDR)) begin
        im_addr_r <= bus.uart_wdata[18:0];
      end else if (im_we_s) begin
        im_addr_r <= im_addr_r + 19'd1;
      end
      if (trap_set_s) trap <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; push and pop never coincide on one request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= 4'd0;
      wr_ptr_r <= 4'd0;
      count_r  <= 5'd0;
    end else if (flush_s) begin
      rd_ptr_r <= 4'd0;
      wr_ptr_r <= 4'd0;
      count_r  <= 5'd0;
    end else if (push_s) begin
      wr_ptr_r <= wr_ptr_r + 4'd1;
      count_r  <= count_r + 5'd1;
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + 4'd1;
      count_r  <= count_r - 5'd1;
    end
  end

  // FIFO storage; data needs no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= bus.uart_wdata[7:0];
  end

  // Image memory write port driven by IM_WDATA.
  always_ff @(posedge clk) begin
    if (im_we_s) image_mem_r[im_addr_r] <= bus.uart_wdata[15:0];
  end

  // Image memory external read port; data holds while the enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_r_data <= 16'd0;
    end else if (im_r_en) begin
      im_r_data <= image_mem_r[im_r_addr];
    end
  end

  // Horizontal/vertical scan counters, one pixel per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= 10'd0;
      vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
    end else begin
      hcnt_r <= hcnt_r + 10'd1;
    end
  end

  // Raw active/sync flags and scan address for the current counter position.
  always_comb begin
    active_s   = (hcnt_r < H_ACTIVE) && (vcnt_r < V_ACTIVE);
    hs_raw_s   = !((hcnt_r >= H_SYNC_FIRST) && (hcnt_r <= H_SYNC_LAST));
    vs_raw_s   = !((vcnt_r >= V_SYNC_FIRST) && (vcnt_r <= V_SYNC_LAST));
    pixel_ADDR = 32'd0;
    if (active_s) begin
      pixel_ADDR = ({22'd0, vcnt_r} * 32'd640) + {22'd0, hcnt_r};
    end else begin
      pixel_ADDR = 32'd0;
    end
  end

  // Two-stage alignment: flags ride alongside the address->data->RGB loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_d1_r <= 1'b0;
      hs_d1_r  <= 1'b1;
      vs_d1_r  <= 1'b1;
      h_sync   <= 1'b1;
      v_sync   <= 1'b1;
      Red      <= 4'd0;
      Green    <= 4'd0;
      Blue     <= 4'd0;
    end else begin
      act_d1_r <= active_s;
      hs_d1_r  <= hs_raw_s;
      vs_d1_r  <= vs_raw_s;
      h_sync   <= hs_d1_r;
      v_sync   <= vs_d1_r;
      if (act_d1_r) begin
        Red   <= pixel[11:8];
        Green <= pixel[7:4];
        Blue  <= pixel[3:0];
      end else begin
        Red   <= 4'd0;
        Green <= 4'd0;
        Blue  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_soc_vga_console_top.sv
// Self-checking bench for soc_vga_console_top: console registers against a
// queue model of the echo FIFO, image memory against an associative-array
// model, and the scan outputs against a position-based model of the frame.
module tb_soc_vga_console_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_vga_console_if #(.ADDR_W(4), .DATA_W(32)) bus_if ();

  logic        trap;
  logic        im_r_en;
  logic [18:0] im_r_addr;
  logic [15:0] im_r_data;
  logic [11:0] pixel;
  logic        v_sync;
  logic        h_sync;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;
  logic [31:0] pixel_ADDR;
  logic        loop_en = 1'b0;
  logic        drv_en = 1'b0;
  logic [18:0] drv_addr = 19'd0;

  // external pixel loop: scan address feeds the read port, read data is the pixel
  assign im_r_addr = loop_en ? pixel_ADDR[18:0] : drv_addr;
  assign im_r_en   = loop_en | drv_en;
  assign pixel     = im_r_data[11:0];

  soc_vga_console_top #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .trap(trap), .bus(bus_if),
    .im_r_en(im_r_en), .im_r_addr(im_r_addr), .im_r_data(im_r_data),
    .pixel(pixel), .v_sync(v_sync), .h_sync(h_sync),
    .Red(Red), .Green(Green), .Blue(Blue), .pixel_ADDR(pixel_ADDR)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] mem_m [int];
  logic [7:0]  fifo_m [$];
  logic [31:0] q;

  // One bus transaction; entered and left at posedge+1.
  task automatic bus_xfer(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    int n;
    bus_if.uart_valid = 1'b1;
    bus_if.uart_addr  = a;
    bus_if.uart_wdata = d;
    bus_if.uart_wstrb = s;
    @(posedge clk); #1;
    bus_if.uart_valid = 1'b0;
    n = 0;
    while (bus_if.uart_ready !== 1'b1 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus_if.uart_ready !== 1'b1 || n != 0) begin
      failures++;
      $display("FAIL bus_ready_latency got_extra_cycles=%0d exp=0", n);
    end
    r = bus_if.uart_rdata;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, d, 4'($urandom_range(1, 15)), dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    bus_xfer(a, 32'd0, 4'd0, r);
  endtask

  task automatic test_reset;
    bus_if.uart_valid = 1'b0;
    bus_if.uart_addr  = 4'd0;
    bus_if.uart_wdata = 32'd0;
    bus_if.uart_wstrb = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL reset_trap got=%0b exp=0", trap); end
    checks++; if (bus_if.uart_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus_if.uart_ready); end
    checks++; if (bus_if.uart_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", bus_if.uart_rdata); end
    checks++; if (im_r_data !== 16'd0) begin failures++; $display("FAIL reset_im_r_data got=%0h exp=0", im_r_data); end
    checks++; if (h_sync !== 1'b1 || v_sync !== 1'b1) begin failures++; $display("FAIL reset_sync got=%0b%0b exp=11", h_sync, v_sync); end
    checks++; if ({Red, Green, Blue} !== 12'd0) begin failures++; $display("FAIL reset_rgb got=%0h exp=0", {Red, Green, Blue}); end
    checks++; if (pixel_ADDR !== 32'd0) begin failures++; $display("FAIL reset_pixel_addr got=%0d exp=0", pixel_ADDR); end
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (mem_m[i]) mem_m.delete(i);
    begin
      logic [3:0] regs [6];
      regs = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
      foreach (regs[i]) begin
        rd(regs[i], q);
        checks++; if (q !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%0h exp=0", regs[i], q); end
      end
    end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    d = $urandom;
    wr(4'd1, d);
    rd(4'd1, q);
    checks++; if (q !== {16'd0, d[15:0]}) begin failures++; $display("FAIL div_readback got=%0h exp=%0h", q, {16'd0, d[15:0]}); end
    for (int a = 11; a <= 15; a++) begin
      rd(4'(a), q);
      checks++; if (q !== 32'd0) begin failures++; $display("FAIL unmapped_read%0d got=%0h exp=0", a, q); end
    end
  endtask

  task automatic test_echo_basic;
    wr(4'd3, 32'd1);
    wr(4'd6, 32'd1);
    wr(4'd2, 32'h41);
    rd(4'd7, q);
    checks++; if (q !== 32'd1) begin failures++; $display("FAIL echo_rxready_before got=%0h exp=1", q); end
    rd(4'd5, q);
    checks++; if (q !== 32'h41) begin failures++; $display("FAIL echo_rxdata got=%0h exp=41", q); end
    rd(4'd7, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL echo_rxready_after got=%0h exp=0", q); end
  endtask

  task automatic test_fifo_full;
    wr(4'd0, 32'd1);
    for (int i = 0; i <= 16; i++) begin
      wr(4'd2, 32'(i));
      if (i == 14) begin
        rd(4'd4, q);
        checks++; if (q !== 32'd1) begin failures++; $display("FAIL full_txready_15 got=%0h exp=1", q); end
      end
      if (i == 15) begin
        rd(4'd4, q);
        checks++; if (q !== 32'd0) begin failures++; $display("FAIL full_txready_16 got=%0h exp=0", q); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'd5, q);
      checks++; if (q !== 32'(i)) begin failures++; $display("FAIL full_order%0d got=%0h exp=%0h", i, q, i); end
    end
    rd(4'd5, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL full_dropped_byte got=%0h exp=0", q); end
    rd(4'd7, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL full_empty_rxready got=%0h exp=0", q); end
  endtask

  task automatic test_softreset;
    for (int i = 0; i < 3; i++) wr(4'd2, 32'(8'hA0 + i));
    wr(4'd0, 32'd2);
    rd(4'd7, q);
    checks++; if (q !== 32'd1) begin failures++; $display("FAIL softreset_bit0_clear got=%0h exp=1", q); end
    wr(4'd0, 32'd1);
    rd(4'd7, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL softreset_rxready got=%0h exp=0", q); end
    rd(4'd4, q);
    checks++; if (q !== 32'd1) begin failures++; $display("FAIL softreset_txready got=%0h exp=1", q); end
  endtask

  task automatic test_back_to_back;
    bus_if.uart_valid = 1'b1;
    bus_if.uart_addr  = 4'd2;
    bus_if.uart_wdata = 32'h5A;
    bus_if.uart_wstrb = 4'hF;
    @(posedge clk); #1;
    checks++; if (bus_if.uart_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_first got=%0b exp=1", bus_if.uart_ready); end
    @(posedge clk); #1;
    checks++; if (bus_if.uart_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_pulse got=%0b exp=0", bus_if.uart_ready); end
    bus_if.uart_valid = 1'b0;
    @(posedge clk); #1;
    rd(4'd5, q);
    checks++; if (q !== 32'h5A) begin failures++; $display("FAIL b2b_rxdata got=%0h exp=5a", q); end
    rd(4'd7, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL b2b_single_push got=%0h exp=0", q); end
  endtask

  task automatic test_random_echo;
    logic txen_m;
    logic rxen_m;
    logic [31:0] d;
    logic [31:0] exp_v;
    txen_m = 1'b1;
    rxen_m = 1'b1;
    fifo_m.delete();
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0: begin d = $urandom; wr(4'd3, d); txen_m = d[0]; end
        1: begin d = $urandom; wr(4'd6, d); rxen_m = d[0]; end
        2, 3, 4: begin
          d = $urandom;
          wr(4'd2, d);
          if (txen_m && fifo_m.size() < 16) fifo_m.push_back(d[7:0]);
        end
        5: begin
          rd(4'd5, q);
          exp_v = (rxen_m && fifo_m.size() > 0) ? {24'd0, fifo_m.pop_front()} : 32'd0;
          checks++; if (q !== exp_v) begin failures++; $display("FAIL rand_rxdata op%0d got=%0h exp=%0h", n, q, exp_v); end
        end
        default: begin
          rd(4'd4, q);
          exp_v = {31'd0, txen_m && fifo_m.size() < 16};
          checks++; if (q !== exp_v) begin failures++; $display("FAIL rand_txready op%0d got=%0h exp=%0h", n, q, exp_v); end
          rd(4'd7, q);
          exp_v = {31'd0, rxen_m && fifo_m.size() > 0};
          checks++; if (q !== exp_v) begin failures++; $display("FAIL rand_rxready op%0d got=%0h exp=%0h", n, q, exp_v); end
        end
      endcase
    end
  endtask

  task automatic test_imem;
    int base;
    logic [31:0] d;
    wr(4'd8, 32'd5);
    wr(4'd9, 32'h0ABC); mem_m[5] = 16'h0ABC;
    wr(4'd9, 32'h0123); mem_m[6] = 16'h0123;
    drv_addr = 19'd6; drv_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (im_r_data !== 16'h0123) begin failures++; $display("FAIL imem_read6 got=%0h exp=123", im_r_data); end
    drv_en = 1'b0; drv_addr = 19'd5;
    @(posedge clk); #1;
    checks++; if (im_r_data !== 16'h0123) begin failures++; $display("FAIL imem_hold got=%0h exp=123", im_r_data); end
    drv_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (im_r_data !== 16'h0ABC) begin failures++; $display("FAIL imem_read5 got=%0h exp=abc", im_r_data); end
    drv_en = 1'b0;
    rd(4'd8, q);
    checks++; if (q !== 32'd7) begin failures++; $display("FAIL imem_ptr got=%0d exp=7", q); end
    base = $urandom_range(1000, 500000);
    wr(4'd8, 32'(base));
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      wr(4'd9, d);
      mem_m[base + i] = d[15:0];
    end
    rd(4'd8, q);
    checks++; if (q !== 32'(base + 8)) begin failures++; $display("FAIL imem_ptr_rand got=%0d exp=%0d", q, base + 8); end
    for (int i = 0; i < 8; i++) begin
      drv_addr = 19'(base + i); drv_en = 1'b1;
      @(posedge clk); #1;
      checks++; if (im_r_data !== mem_m[base + i]) begin failures++; $display("FAIL imem_rand%0d got=%0h exp=%0h", i, im_r_data, mem_m[base + i]); end
    end
    drv_en = 1'b0;
    wr(4'd8, 32'h7FFFF);
    d = $urandom;
    wr(4'd9, d);
    mem_m[32'h7FFFF] = d[15:0];
    rd(4'd8, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL imem_wrap_ptr got=%0h exp=0", q); end
    drv_addr = 19'h7FFFF; drv_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (im_r_data !== mem_m[32'h7FFFF]) begin failures++; $display("FAIL imem_wrap_data got=%0h exp=%0h", im_r_data, mem_m[32'h7FFFF]); end
    drv_en = 1'b0;
  endtask

  task automatic test_trap;
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL trap_initial got=%0b exp=0", trap); end
    wr(4'd10, 32'd2);
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL trap_bit0_clear got=%0b exp=0", trap); end
    wr(4'd10, 32'd1);
    checks++; if (trap !== 1'b1) begin failures++; $display("FAIL trap_set got=%0b exp=1", trap); end
    wr(4'd0, 32'd1);
    rd(4'd1, q);
    checks++; if (trap !== 1'b1) begin failures++; $display("FAIL trap_sticky got=%0b exp=1", trap); end
  endtask

  task automatic test_vga;
    logic [31:0] d;
    int p, x, y, hs_low;
    logic act, exp_hs, exp_vs, known;
    logic [11:0] exp_rgb;
    logic [31:0] exp_addr;
    wr(4'd8, 32'd0);
    wr(4'd9, 32'h0F0A); mem_m[0] = 16'h0F0A;
    for (int i = 1; i < 40; i++) begin
      d = $urandom;
      wr(4'd9, d);
      mem_m[i] = d[15:0];
    end
    rst = 1'b1; loop_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL vga_reset_trap got=%0b exp=0", trap); end
    rst = 1'b0;
    hs_low = 0;
    // after k edges since release the scan sits at position k; RGB/sync show position k-2
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk); #1;
      x = k % 800; y = (k / 800) % 525;
      act = (x < 640) && (y < 480);
      exp_addr = act ? 32'(y * 640 + x) : 32'd0;
      checks++; if (pixel_ADDR !== exp_addr) begin failures++; $display("FAIL vga_addr k%0d got=%0d exp=%0d", k, pixel_ADDR, exp_addr); end
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'd0; known = 1'b1;
      if (k >= 2) begin
        p = k - 2; x = p % 800; y = (p / 800) % 525;
        act = (x < 640) && (y < 480);
        exp_hs = !((x >= 656) && (x <= 751));
        exp_vs = !((y >= 490) && (y <= 491));
        if (act) begin
          known = (y == 0) && (x < 40);
          if (known) exp_rgb = mem_m[x][11:0];
        end
        if (k <= 801 && h_sync == 1'b0) hs_low++;
      end
      checks++; if (h_sync !== exp_hs || v_sync !== exp_vs) begin failures++; $display("FAIL vga_sync k%0d got=%0b%0b exp=%0b%0b", k, h_sync, v_sync, exp_hs, exp_vs); end
      if (known) begin
        checks++; if ({Red, Green, Blue} !== exp_rgb) begin failures++; $display("FAIL vga_rgb k%0d got=%0h exp=%0h", k, {Red, Green, Blue}, exp_rgb); end
      end
    end
    checks++; if (hs_low != 96) begin failures++; $display("FAIL vga_hsync_width got=%0d exp=96", hs_low); end
  endtask

  task automatic test_reset_midline;
    int n;
    wr(4'd3, 32'd1);
    wr(4'd2, 32'h77);
    wr(4'd10, 32'd1);
    checks++; if (trap !== 1'b1) begin failures++; $display("FAIL midline_trap_set got=%0b exp=1", trap); end
    n = 0;
    while (h_sync !== 1'b0 && n < 900) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (h_sync !== 1'b0) begin failures++; $display("FAIL midline_hsync_wait got=%0b exp=0", h_sync); end
    rst = 1'b1;
    #2;
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL midline_trap got=%0b exp=0", trap); end
    checks++; if (pixel_ADDR !== 32'd0) begin failures++; $display("FAIL midline_pixel_addr got=%0d exp=0", pixel_ADDR); end
    checks++; if (h_sync !== 1'b1 || v_sync !== 1'b1) begin failures++; $display("FAIL midline_sync got=%0b%0b exp=11", h_sync, v_sync); end
    checks++; if ({Red, Green, Blue} !== 12'd0) begin failures++; $display("FAIL midline_rgb got=%0h exp=0", {Red, Green, Blue}); end
    @(posedge clk); #1;
    rst = 1'b0;
    wr(4'd6, 32'd1);
    rd(4'd7, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL midline_fifo_cleared got=%0h exp=0", q); end
    rd(4'd3, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL midline_txen_cleared got=%0h exp=0", q); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_echo_basic();
    test_fifo_full();
    test_softreset();
    test_back_to_back();
    test_random_echo();
    test_imem();
    test_trap();
    test_vga();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
